mux_arb_nx1: RTL and testbench
==============================

Name: mux_arb_nx1

Overview:
- Parametrised N-to-1 multiplexer with a registered output and valid/ready handshake on every channel.
- Two modes:
  - fixed: an external select picks the channel.
  - round-robin: an internal fair arbiter picks among valid channels.
- Sits between several producer streams and one consumer. One output register stage decouples timing.

Parameters:
WIDTH, 8, data width per channel
NUM_CH, 4, number of input channels (>=2)
SEL_W, $clog2(NUM_CH), width of channel index (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mode  in  1  0 = fixed select, 1 = round-robin
sel  in  SEL_W  channel index used in fixed mode
in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  in  NUM_CH  per-channel valid
in_ready  out  NUM_CH  per-channel ready (combinational)
out_data  out  WIDTH  registered output word
out_ch  out  SEL_W  index of channel that supplied out_data
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts out_data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the rising clk edge.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr pointer=0. in_ready is all 0 while rst=1.
- Reset mid-operation discards any held word; no transfer is reported in that cycle.
- load = !out_valid || out_ready. The stage accepts a new word when empty or when draining in the same cycle.
- Grant is one-hot, at most one bit set; it is computed combinationally every cycle.
- Fixed mode: grant[sel] = in_valid[sel]. If sel >= NUM_CH, no grant.
- Round-robin mode: grant goes to the first i with in_valid[i]=1, scanning ptr, ptr+1, ... wrapping modulo NUM_CH.
- in_ready[i] = load && grant[i] && !rst. Input transfer on channel i = in_valid[i] && in_ready[i].
- On an input transfer (posedge clk): out_data <= that channel's word, out_ch <= i, out_valid <= 1.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Output transfer: out_valid && out_ready. If no input transfer occurs in that cycle, out_valid <= 0.
- Simultaneous output drain and new input transfer: out_valid stays 1 and the new word loads, giving full throughput of 1 word/cycle.
- Stall: out_valid=1 and out_ready=0 holds out_data and out_ch stable, and all in_ready are 0.
- Pointer: in round-robin mode ptr <= (i+1) mod NUM_CH on an input transfer from channel i. For the top channel ptr wraps to 0.
- The pointer is unchanged in fixed mode and on cycles without a transfer.
- mode and sel may change any cycle. They affect only the next grant and never a held output word.
- No valid inputs: no grant, and out_valid falls after the held word drains.
- Consumer keeps out_ready=1 while inputs stay valid: no bubbles.

Decomposition:
- Package mux_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Helper function onehot_to_index (priority-free, assumes one-hot).
- Sub-module rr_arbiter (parameter NUM_CH):
  - Inputs: clk, rst, req[NUM_CH], advance (the transfer strobe).
  - Outputs: grant[NUM_CH], plus the registered pointer.
  - Uses a double-width rotate-and-priority scheme.
- The top level contains:
  - the fixed-select path,
  - the mode mux between fixed grant and rr grant,
  - the data mux driven by the one-hot grant,
  - the output register and the load/ready logic.

Test Plan (WIDTH=8, NUM_CH=4):
1. Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=4'b0000. After release, the first grant in RR mode is ch0.
2. Fixed mode: sel=2, in_data ch2=0xA5, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_ch=2, out_valid=1; other channels are never granted.
3. Round-robin fairness: all valid, out_ready=1, ch data 0x10/0x21/0x32/0x43 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles. Then in_valid=4'b1010 -> grants alternate 1,3.
4. Backpressure: out_valid=1 holding 0x21, out_ready=0 for 3 cycles -> out_data/out_ch stable and in_ready=0. The cycle out_ready returns to 1, the next word is accepted simultaneously and out_valid stays 1.
5. Mode switch mid-stream: RR with ptr=2, switch to fixed sel=0 -> only ch0 is granted and ptr stays 2. Switching back to RR resumes from ch2.
6. Reset mid-operation: word 0x43 held with out_ready=0, pulse rst 1 cycle -> out_valid=0 and ptr=0 next cycle; 0x43 never appears as transferred.

Source files
------------

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared constants and helpers for the N-to-1 arbitrated mux.
//                - MODE_FIXED / MODE_RR : values of the mode input
//                - onehot_to_index      : OR-based one-hot to binary encoder
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    // Mode input encoding
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // The encoder works on a fixed-width vector. Callers zero-pad their
    // grant vector up to ONEHOT_MAX_W and keep the low index bits.
    // Channel counts up to 128 are supported (index fits in 7 bits, which
    // leaves at least one upper bit for callers to discard).
    localparam int ONEHOT_MAX_W = 256;
    localparam int ONEHOT_IDX_W = 8;

    // Priority-free encoder: every set bit ORs its index into the result.
    // With a one-hot (or all-zero) input this yields the bit position
    // (or zero); no priority chain is built.
    function automatic logic [ONEHOT_IDX_W-1:0] onehot_to_index(
        input logic [ONEHOT_MAX_W-1:0] onehot
    );
        logic [ONEHOT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (onehot[i]) begin
                idx = idx | ONEHOT_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Fair round-robin arbiter with a registered priority pointer.
//                The request vector is rotated so the pointer position sits
//                at bit 0, the lowest set bit is isolated, and the result is
//                rotated back. On each advance strobe the pointer moves to
//                one past the granted channel, wrapping at NUM_CH.
//  Ports       : clk     - clock, rising edge
//                rst     - synchronous active-high reset (pointer -> 0)
//                req     - per-channel request
//                advance - a grant from this arbiter was consumed this cycle
//                grant   - one-hot grant (combinational), zero if no request
//                ptr     - current highest-priority channel index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  ptr
);

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]        r_ptr;
    logic [NUM_CH-1:0]       w_rot_req;
    logic [NUM_CH-1:0]       w_rot_grant;
    logic [ONEHOT_IDX_W-1:0] w_idx_full;
    logic [SEL_W-1:0]        w_idx;
    logic                    w_unused_idx_hi;

    // Rotate right by the pointer: bit j of the rotated vector is
    // req[(j + ptr) mod NUM_CH], so the search starts at the pointer.
    assign w_rot_req = NUM_CH'({req, req} >> r_ptr);

    // Isolate the lowest set bit (two's-complement trick).
    assign w_rot_grant = w_rot_req & (~w_rot_req + NUM_CH'(1));

    // Rotate back: the upper half of the doubled, left-shifted vector holds
    // the grant in original channel numbering.
    assign grant = NUM_CH'(({w_rot_grant, w_rot_grant} << r_ptr) >> NUM_CH);

    assign w_idx_full      = onehot_to_index({{(ONEHOT_MAX_W-NUM_CH){1'b0}}, grant});
    assign w_idx           = w_idx_full[SEL_W-1:0];
    assign w_unused_idx_hi = ^w_idx_full[ONEHOT_IDX_W-1:SEL_W];

    // Pointer moves one past the winner; explicit wrap keeps non-power-of-two
    // channel counts inside the legal index range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && (|grant)) begin
            if (w_idx == c_last_ch) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + SEL_W'(1);
            end
        end
    end

    assign ptr = r_ptr;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_arb_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_nx1
//  Description : N-to-1 stream multiplexer with a single registered output
//                stage and valid/ready handshakes on every channel.
//                mode = 0 : the channel named by sel is forwarded.
//                mode = 1 : a round-robin arbiter picks among valid channels.
//                The output register accepts a new word when empty or when
//                its current word drains in the same cycle (1 word/cycle).
//  Ports       : clk, rst   - clock / synchronous active-high reset
//                mode, sel  - channel selection control
//                in_data    - channel i at bits [i*WIDTH +: WIDTH]
//                in_valid   - per-channel valid
//                in_ready   - per-channel ready (combinational)
//                out_data   - registered output word
//                out_ch     - channel that supplied out_data
//                out_valid  - output word valid
//                out_ready  - consumer accepts out_data
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [NUM_CH-1:0]       w_fix_grant;
    logic [NUM_CH-1:0]       w_rr_grant;
    logic [NUM_CH-1:0]       w_grant;
    logic                    w_load;
    logic                    w_xfer;
    logic                    w_rr_advance;
    logic [WIDTH-1:0]        w_mux_data;
    logic [ONEHOT_IDX_W-1:0] w_grant_idx_full;
    logic [SEL_W-1:0]        w_grant_idx;
    logic                    w_unused_idx_hi;
    logic [SEL_W-1:0]        w_unused_rr_ptr;

    logic [WIDTH-1:0]        r_out_data;
    logic [SEL_W-1:0]        r_out_ch;
    logic                    r_out_valid;

    // ------------------------------------------------------------------
    // Fixed-select path. A sel value with no matching channel (possible
    // when NUM_CH is not a power of two) matches no bit and grants nothing.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fix_grant
        assign w_fix_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
    end

    // ------------------------------------------------------------------
    // Round-robin path. The pointer only moves when the arbiter's grant
    // is actually consumed, so fixed-mode traffic leaves it untouched.
    // ------------------------------------------------------------------
    assign w_rr_advance = w_xfer && (mode == MODE_RR);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (w_rr_advance),
        .grant   (w_rr_grant),
        .ptr     (w_unused_rr_ptr)
    );

    // Mode mux: mode/sel only steer the grant for the next load, never the
    // word already held in the output register.
    assign w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;

    // ------------------------------------------------------------------
    // Handshake: the stage can take a word when empty or draining.
    // ------------------------------------------------------------------
    assign w_load   = !r_out_valid || out_ready;
    assign in_ready = (w_load && !rst) ? w_grant : '0;
    // Every grant bit already implies the matching in_valid.
    assign w_xfer   = |in_ready;

    // AND-OR data mux driven by the one-hot grant.
    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_mux_data = w_mux_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_grant_idx_full = onehot_to_index({{(ONEHOT_MAX_W-NUM_CH){1'b0}}, w_grant});
    assign w_grant_idx      = w_grant_idx_full[SEL_W-1:0];
    assign w_unused_idx_hi  = ^w_grant_idx_full[ONEHOT_IDX_W-1:SEL_W];

    // ------------------------------------------------------------------
    // Output register. Reset discards any held word outright; in_ready is
    // forced low during reset, so nothing is accepted in that cycle either.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_mux_data;
                r_out_ch   <= w_grant_idx;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule : mux_arb_nx1
`default_nettype wire

// File: tb/tb_mux_arb_nx1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb_nx1
//  Description : Self-checking bench for mux_arb_nx1 (WIDTH=8, NUM_CH=4).
//                A small reference model predicts the grant each cycle and
//                pushes expected {channel, data} words into a scoreboard
//                queue; a monitor pops and compares on every output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_nx1;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_ptr  = 0;
    bit         m_full = 1'b0;
    logic [9:0] sbq[$];   // {ch[1:0], data[7:0]}

    always #5 clk = ~clk;

    mux_arb_nx1 #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        int         c;
        g = 4'b0000;
        if (rst || !(!m_full || out_ready)) return g;
        if (mode == 1'b0) begin
            if (in_valid[sel]) g[sel] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_ptr + k) % NUM_CH;
                if (in_valid[c]) begin
                    g[c] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    // Applies the effect of the coming rising edge to the model.
    task automatic model_commit(input logic [3:0] g);
        logic [1:0] kc;
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sbq.delete();
            return;
        end
        if (!m_full || out_ready) begin
            m_full = (g != 4'b0000);
            for (int k = 0; k < NUM_CH; k++) begin
                if (g[k]) begin
                    kc = 2'(k);
                    sbq.push_back({kc, in_data[k*8 +: 8]});
                    if (mode) m_ptr = (k + 1) % NUM_CH;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    endtask

    task automatic drain();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            model_commit(model_grant());
            tick();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [9:0] exp_w;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d data=0x%02h, required no output transfer",
                         out_ch, out_data);
            end else begin
                exp_w = sbq.pop_front();
                if ({out_ch, out_data} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_word: got ch=%0d data=0x%02h, required ch=%0d data=0x%02h",
                             out_ch, out_data, exp_w[9:8], exp_w[7:0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        set_default_data();
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=0x%02h ch=%0d, required v=0 d=0x00 ch=0",
                     out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end
        model_commit(model_grant());
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_rr_grant: got %b, required 0001", in_ready);
        end
        model_commit(model_grant());
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_latency: got out_valid=%b, required 1", out_valid);
        end
        model_commit(model_grant());
        tick();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data[23:16] = 8'hA5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL fixed_in_ready: got %b, required 0100", in_ready);
            end
            if (c > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL fixed_output: got v=%b ch=%0d d=0x%02h, required v=1 ch=2 d=0xa5",
                             out_valid, out_ch, out_data);
                end
            end
            model_commit(model_grant());
            tick();
        end
        drain();
        set_default_data();
    endtask

    task automatic test_rr_fairness();
        int         seq[6] = '{0, 1, 2, 3, 0, 1};
        int         alt[4] = '{3, 1, 3, 1};
        logic [3:0] one = 4'b0001;
        // Known pointer start: one reset cycle.
        rst = 1'b1;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== (one << seq[c])) begin
                errors++;
                $display("FAIL rr_seq_grant[%0d]: got %b, required ch%0d", c, in_ready, seq[c]);
            end
            if (c > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_ch !== 2'(seq[c-1])) begin
                    errors++;
                    $display("FAIL rr_no_bubble[%0d]: got v=%b ch=%0d, required v=1 ch=%0d",
                             c, out_valid, out_ch, seq[c-1]);
                end
            end
            model_commit(model_grant());
            tick();
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== (one << alt[c])) begin
                errors++;
                $display("FAIL rr_alt_grant[%0d]: got %b, required ch%0d", c, in_ready, alt[c]);
            end
            model_commit(model_grant());
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        in_valid = 4'b1111; out_ready = 1'b0;
        in_data[15:8] = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b d=0x%02h ch=%0d rdy=%b, required v=1 d=0x21 ch=1 rdy=0000",
                         c, out_valid, out_data, out_ch, in_ready);
            end
            model_commit(model_grant());
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release_ready: got %b, required 0010", in_ready);
        end
        model_commit(model_grant());
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL stall_release_load: got v=%b d=0x%02h ch=%0d, required v=1 d=0x5a ch=1",
                     out_valid, out_data, out_ch);
        end
        model_commit(model_grant());
        tick();
        drain();
        set_default_data();
    endtask

    task automatic test_mode_switch();
        // Pointer is 2 here; ch1 alone wins and leaves it at 2.
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mode_rr_setup: got %b, required 0010", in_ready);
        end
        model_commit(model_grant());
        tick();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0001) begin
                errors++;
                $display("FAIL mode_fixed_grant[%0d]: got %b, required 0001", c, in_ready);
            end
            model_commit(model_grant());
            tick();
        end
        mode = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mode_rr_resume: got %b, required 0100", in_ready);
        end
        model_commit(model_grant());
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        // Pointer is 3 here; ch1 wins and moves it to 2.
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_load_ready: got %b, required 1000", in_ready);
        end
        model_commit(model_grant());
        tick();
        in_valid = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h43 || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_held: got v=%b d=0x%02h ch=%0d, required v=1 d=0x43 ch=3",
                     out_valid, out_data, out_ch);
        end
        model_commit(model_grant());
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %b, required 0000", in_ready);
        end
        model_commit(model_grant());
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_cleared: got v=%b d=0x%02h ch=%0d, required v=0 d=0x00 ch=0",
                     out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr_reset: got %b, required 0001", in_ready);
        end
        model_commit(model_grant());
        tick();
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered words, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_arb_nx1
`default_nettype wire
